axi_lite_rd_arbiter: RTL and testbench

- Shares one AXI-lite read port (memory/interconnect side) between two read masters: M0 = fetch stage, M1 = load unit.
- Round-robin arbitration with one outstanding transaction at a time.
- Placed between the core's fetch/load units and the instruction/data memory read channel.
- The address is registered internally, so master ARADDR only needs to be valid in its accept cycle.

---
 rtl/axi_lite_rd_arbiter_if.sv | 25 ++
 rtl/axi_lite_rd_arbiter.sv | 105 ++++++++++
 tb/tb_axi_lite_rd_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_rd_arbiter_if.sv
// AXI-lite read channel bundle (AR + R) shared by both arbiter sides.
//   master modport: drives ARADDR/ARVALID/RREADY, receives ARREADY/RDATA/RRESP/RVALID.
//   slave  modport: the mirror image.
interface axi_lite_rd_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RVALID;
  logic                  RREADY;

  modport master (
    output ARADDR, ARVALID, RREADY,
    input  ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  ARADDR, ARVALID, RREADY,
    output ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi_lite_rd_arbiter.sv
// Two-master round-robin arbiter onto one AXI-lite read port, one transaction in flight.
//   clk   : rising-edge clock
//   rst   : asynchronous active-low reset
//   m0    : fetch-stage read channel (arbiter acts as its slave)
//   m1    : load-unit read channel (arbiter acts as its slave)
//   s     : shared read channel towards memory (arbiter acts as master)
//   owner : current or most recent grant (0 = m0, 1 = m1)
module axi_lite_rd_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  axi_lite_rd_arbiter_if.slave  m0,
  axi_lite_rd_arbiter_if.slave  m1,
  axi_lite_rd_arbiter_if.master s,
  output logic                  owner
);

  localparam logic [DATA_WIDTH-1:0] NoData = '0;

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  grant_q, grant_d;
  logic                  last_q, last_d;
  logic                  pick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;  // makes m0 win the first tie
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    grant_d    = grant_q;
    last_d     = last_q;
    m0.ARREADY = 1'b0;
    m0.RVALID  = 1'b0;
    m0.RDATA   = NoData;
    m0.RRESP   = 2'b00;
    m1.ARREADY = 1'b0;
    m1.RVALID  = 1'b0;
    m1.RDATA   = NoData;
    m1.RRESP   = 2'b00;
    s.ARADDR   = addr_q;
    s.ARVALID  = 1'b0;
    s.RREADY   = 1'b0;
    // On a tie the master that did not finish last wins; otherwise whoever asks.
    pick = (m0.ARVALID && m1.ARVALID) ? ~last_q : m1.ARVALID;

    unique case (state_q)
      StIdle: begin
        // rst gate keeps ARREADY low while reset is held (state is already idle then).
        if (rst && (m0.ARVALID || m1.ARVALID)) begin
          if (pick) begin
            m1.ARREADY = 1'b1;
            addr_d     = m1.ARADDR;
          end else begin
            m0.ARREADY = 1'b1;
            addr_d     = m0.ARADDR;
          end
          grant_d = pick;
          state_d = StAddr;
        end
      end
      StAddr: begin
        s.ARVALID = 1'b1;
        if (s.ARREADY) state_d = StData;
      end
      StData: begin
        if (grant_q) begin
          m1.RVALID = s.RVALID;
          m1.RDATA  = s.RDATA;
          m1.RRESP  = s.RRESP;
          s.RREADY  = m1.RREADY;
        end else begin
          m0.RVALID = s.RVALID;
          m0.RDATA  = s.RDATA;
          m0.RRESP  = s.RRESP;
          s.RREADY  = m0.RREADY;
        end
        if (s.RVALID && s.RREADY) begin
          last_d  = grant_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign owner = grant_q;

endmodule

// File: tb/tb_axi_lite_rd_arbiter.sv
// Directed bench for axi_lite_rd_arbiter: transaction-level model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_axi_lite_rd_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic owner;

  axi_lite_rd_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m0_bus ();
  axi_lite_rd_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m1_bus ();
  axi_lite_rd_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_bus ();

  axi_lite_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .m0    (m0_bus),
    .m1    (m1_bus),
    .s     (s_bus),
    .owner (owner)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- slave responder ----------------
  int          ar_lat   = 0;  // cycles ARREADY stays low once ARVALID is seen
  int          r_lat    = 0;  // extra cycles before RVALID after the AR handshake
  logic [1:0]  resp_cfg = 2'b00;

  initial begin : slave_proc
    bit          ar_hs, r_hs, pending;
    logic [31:0] hs_addr, rdat;
    int          ar_cnt, r_cnt;
    pending = 0; ar_cnt = 0; r_cnt = 0; rdat = '0;
    s_bus.ARREADY = 1'b0;
    s_bus.RVALID  = 1'b0;
    s_bus.RDATA   = '0;
    s_bus.RRESP   = 2'b00;
    forever begin
      @(negedge clk);
      ar_hs   = s_bus.ARVALID && s_bus.ARREADY;
      r_hs    = s_bus.RVALID && s_bus.RREADY;
      hs_addr = s_bus.ARADDR;
      @(posedge clk);
      #2;
      if (!rst) begin
        s_bus.ARREADY = 1'b0;
        s_bus.RVALID  = 1'b0;
        pending = 0;
        ar_cnt  = 0;
      end else begin
        if (r_hs) s_bus.RVALID = 1'b0;
        if (ar_hs) begin
          pending = 1;
          rdat    = hs_addr + 32'd3;
          r_cnt   = 0;
        end
        if (pending) begin
          if (r_cnt >= r_lat) begin
            s_bus.RVALID = 1'b1;
            s_bus.RDATA  = rdat;
            s_bus.RRESP  = resp_cfg;
            pending = 0;
          end else r_cnt++;
        end
        if (s_bus.ARVALID) begin
          if (ar_cnt >= ar_lat) s_bus.ARREADY = 1'b1;
          else begin
            s_bus.ARREADY = 1'b0;
            ar_cnt++;
          end
        end else begin
          s_bus.ARREADY = 1'b0;
          ar_cnt = 0;
        end
      end
    end
  end

  // ---------------- transaction-level model + per-cycle compare ----------------
  bit          t_busy = 0;   // a transaction has been accepted and not yet returned
  bit          t_sent = 0;   // its address has been taken by the slave
  bit          t_who  = 0;
  logic [31:0] t_addr = '0;
  bit          t_last = 1;
  logic [31:0] ar_log[$];

  always @(negedge clk) begin : compare_proc
    logic        e_ar0, e_ar1, e_sarv, e_srr, e_rv0, e_rv1, e_own, winner, rr;
    logic [31:0] e_saddr, e_rd0, e_rd1;
    logic [1:0]  e_rr0, e_rr1;
    e_ar0 = 0; e_ar1 = 0; e_sarv = 0; e_srr = 0; e_rv0 = 0; e_rv1 = 0; e_own = 0;
    e_saddr = '0; e_rd0 = '0; e_rd1 = '0; e_rr0 = 2'b00; e_rr1 = 2'b00; winner = 0; rr = 0;
    if (!rst) begin
      t_busy = 0; t_sent = 0; t_who = 0; t_addr = '0; t_last = 1;
    end else begin
      winner  = (m0_bus.ARVALID && m1_bus.ARVALID) ? !t_last : m1_bus.ARVALID;
      e_saddr = t_addr;
      e_own   = t_who;
      if (!t_busy) begin
        if (m0_bus.ARVALID || m1_bus.ARVALID) begin
          if (winner) e_ar1 = 1; else e_ar0 = 1;
        end
      end else if (!t_sent) begin
        e_sarv = 1;
      end else begin
        rr    = t_who ? m1_bus.RREADY : m0_bus.RREADY;
        e_srr = rr;
        if (t_who) begin
          e_rv1 = s_bus.RVALID; e_rd1 = s_bus.RDATA; e_rr1 = s_bus.RRESP;
        end else begin
          e_rv0 = s_bus.RVALID; e_rd0 = s_bus.RDATA; e_rr0 = s_bus.RRESP;
        end
      end
    end
    chk("cyc m0_ARREADY", m0_bus.ARREADY, e_ar0);
    chk("cyc m1_ARREADY", m1_bus.ARREADY, e_ar1);
    chk("cyc s_ARVALID",  s_bus.ARVALID,  e_sarv);
    chk("cyc s_ARADDR",   s_bus.ARADDR,   e_saddr);
    chk("cyc s_RREADY",   s_bus.RREADY,   e_srr);
    chk("cyc m0_R",       {m0_bus.RVALID, m0_bus.RRESP, m0_bus.RDATA}, {e_rv0, e_rr0, e_rd0});
    chk("cyc m1_R",       {m1_bus.RVALID, m1_bus.RRESP, m1_bus.RDATA}, {e_rv1, e_rr1, e_rd1});
    chk("cyc owner",      owner,          e_own);
    if (rst) begin
      if (!t_busy && (m0_bus.ARVALID || m1_bus.ARVALID)) begin
        t_busy = 1; t_sent = 0; t_who = winner;
        t_addr = winner ? m1_bus.ARADDR : m0_bus.ARADDR;
      end else if (t_busy && !t_sent && s_bus.ARREADY) begin
        t_sent = 1;
        ar_log.push_back(s_bus.ARADDR);
      end else if (t_busy && t_sent && s_bus.RVALID && rr) begin
        t_busy = 0;
        t_last = t_who;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin : stim
    int k;
    m0_bus.ARVALID = 0; m0_bus.ARADDR = '0; m0_bus.RREADY = 1;
    m1_bus.ARVALID = 0; m1_bus.ARADDR = '0; m1_bus.RREADY = 1;
    idle(2);
    rst = 1;
    #2;
    chk("reset owner", owner, 0);
    chk("reset s_ARADDR", s_bus.ARADDR, 0);

    // Single m0 read: 0x10 -> 0x13.
    step();
    m0_bus.ARVALID = 1; m0_bus.ARADDR = 32'h10;
    #2;
    chk("t1 m0_ARREADY c0", m0_bus.ARREADY, 1);
    chk("t1 s_ARVALID c0", s_bus.ARVALID, 0);
    step();
    m0_bus.ARVALID = 0; m0_bus.ARADDR = '0;
    #2;
    chk("t1 s_ARVALID c1", s_bus.ARVALID, 1);
    chk("t1 s_ARADDR c1", s_bus.ARADDR, 32'h10);
    step();
    #2;
    chk("t1 m0_RVALID c2", m0_bus.RVALID, 1);
    chk("t1 m0_RDATA c2", m0_bus.RDATA, 32'h13);
    chk("t1 m1_RVALID c2", m1_bus.RVALID, 0);
    step();
    #2;
    chk("t1 m0_RVALID c3", m0_bus.RVALID, 0);
    idle(2);

    // Tie right after reset, then strict alternation.
    rst = 0;
    idle(2);
    rst = 1;
    ar_log.delete();
    m0_bus.ARVALID = 1; m0_bus.ARADDR = 32'h100;
    m1_bus.ARVALID = 1; m1_bus.ARADDR = 32'h200;
    #2;
    chk("t2 first tie m0_ARREADY", m0_bus.ARREADY, 1);
    chk("t2 first tie m1_ARREADY", m1_bus.ARREADY, 0);
    k = 0;
    while (ar_log.size() < 4 && k < 40) begin
      step();
      k++;
    end
    chk("t2 grants done in budget", ar_log.size() >= 4, 1);
    m0_bus.ARVALID = 0; m1_bus.ARVALID = 0;
    if (ar_log.size() >= 4) begin
      chk("t2 grant0", ar_log[0], 32'h100);
      chk("t2 grant1", ar_log[1], 32'h200);
      chk("t2 grant2", ar_log[2], 32'h100);
      chk("t2 grant3", ar_log[3], 32'h200);
    end
    idle(6);

    // Slave holds ARREADY low 5 cycles; m1 asks meanwhile and must wait.
    ar_lat = 5;
    m0_bus.ARVALID = 1; m0_bus.ARADDR = 32'h300;
    #2;
    chk("t3 m0_ARREADY accept", m0_bus.ARREADY, 1);
    step();
    m0_bus.ARVALID = 0;
    m1_bus.ARVALID = 1; m1_bus.ARADDR = 32'h400;
    for (int i = 0; i < 5; i++) begin
      #2;
      chk("t3 s_ARVALID held", s_bus.ARVALID, 1);
      chk("t3 s_ARADDR held", s_bus.ARADDR, 32'h300);
      chk("t3 no m0_ARREADY", m0_bus.ARREADY, 0);
      chk("t3 no m1_ARREADY", m1_bus.ARREADY, 0);
      step();
    end
    #2;
    chk("t3 s_ARREADY after wait", s_bus.ARREADY, 1);
    step();
    ar_lat = 0;
    #2;
    chk("t3 m0_RDATA", m0_bus.RDATA, 32'h303);
    chk("t3 m0_RVALID", m0_bus.RVALID, 1);
    step();
    #2;
    chk("t3 m1 granted next", m1_bus.ARREADY, 1);
    step();
    m1_bus.ARVALID = 0;
    idle(6);

    // m1 read with RREADY low while data is held by the slave.
    resp_cfg = 2'b10;
    m1_bus.RREADY = 0;
    m1_bus.ARVALID = 1; m1_bus.ARADDR = 32'hDEAD_BEEC;
    #2;
    chk("t4 m1_ARREADY", m1_bus.ARREADY, 1);
    step();
    m1_bus.ARVALID = 0;
    #2;
    k = 0;
    while (!m1_bus.RVALID && k < 10) begin
      step();
      #2;
      k++;
    end
    chk("t4 m1_RVALID in budget", m1_bus.RVALID, 1);
    for (int i = 0; i < 3; i++) begin
      chk("t4 s_RREADY low", s_bus.RREADY, 0);
      chk("t4 m1_RVALID held", m1_bus.RVALID, 1);
      chk("t4 m1_RDATA", m1_bus.RDATA, 32'hDEAD_BEEF);
      chk("t4 m1_RRESP", m1_bus.RRESP, 2'b10);
      chk("t4 m0_RVALID", m0_bus.RVALID, 0);
      if (i < 2) begin
        step();
        #2;
      end
    end
    step();
    m1_bus.RREADY = 1;
    #2;
    chk("t4 s_RREADY on accept", s_bus.RREADY, 1);
    chk("t4 m1_RVALID on accept", m1_bus.RVALID, 1);
    step();
    #2;
    chk("t4 m1_RVALID after", m1_bus.RVALID, 0);
    resp_cfg = 2'b00;
    idle(4);

    // Reset during DATA, with both masters requesting.
    r_lat = 3;
    m0_bus.ARVALID = 1; m0_bus.ARADDR = 32'h500;
    step();
    m0_bus.ARVALID = 0;
    step();
    m0_bus.ARVALID = 1; m0_bus.ARADDR = 32'h600;
    m1_bus.ARVALID = 1; m1_bus.ARADDR = 32'h700;
    #2;
    chk("t5 in DATA s_RREADY", s_bus.RREADY, 1);
    chk("t5 in DATA m0_RVALID", m0_bus.RVALID, 0);
    step();
    rst = 0;
    #1;
    chk("t5 rst m0_ARREADY", m0_bus.ARREADY, 0);
    chk("t5 rst m1_ARREADY", m1_bus.ARREADY, 0);
    chk("t5 rst s_ARVALID", s_bus.ARVALID, 0);
    chk("t5 rst s_RREADY", s_bus.RREADY, 0);
    chk("t5 rst s_ARADDR", s_bus.ARADDR, 0);
    chk("t5 rst owner", owner, 0);
    chk("t5 rst RVALIDs", {m0_bus.RVALID, m1_bus.RVALID}, 0);
    idle(2);
    r_lat = 0;
    rst = 1;
    #2;
    chk("t5 tie after rst m0", m0_bus.ARREADY, 1);
    chk("t5 tie after rst m1", m1_bus.ARREADY, 0);
    step();
    m0_bus.ARVALID = 0;
    #2;
    k = 0;
    while (!m1_bus.ARREADY && k < 10) begin
      step();
      #2;
      k++;
    end
    chk("t5 m1 granted after m0", m1_bus.ARREADY, 1);
    step();
    m1_bus.ARVALID = 0;
    idle(6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1, "timeout");
  end

endmodule
